// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage
// and main memory. Read hits are combinational; misses refill a line via a burst.
module data_cache #(
   parameter int WIDTH      = 32,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_we,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             stall,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = WIDTH - IDX_W - OFF_W - 2;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, RD_REQ, RD_BEAT, WR} state_t;

   state_t           state_q, state_d;
   logic [OFF_W-1:0] beat_q, beat_d;
   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [WIDTH-1:0] data_q [SETS][LINE_WORDS];

   logic [OFF_W-1:0] offset;
   logic [IDX_W-1:0] index;
   logic [TAG_W-1:0] tag;
   logic             hit, last_beat, refill_we, store_hit_we;
   logic             unused_addr_bits;

   assign offset           = req_addr[OFF_W+1:2];
   assign index            = req_addr[OFF_W+2 +: IDX_W];
   assign tag              = req_addr[WIDTH-1 -: TAG_W];
   assign hit              = valid_q[index] && (tag_q[index] == tag);
   assign last_beat        = mem_rvalid && (beat_q == LAST_BEAT);
   assign refill_we        = (state_q == RD_BEAT) && mem_rvalid;
   assign store_hit_we     = (state_q == WR) && mem_req_ready && hit;
   assign unused_addr_bits = ^req_addr[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE:    if (req_valid) begin
                     if (req_we)   state_d = WR;
                     else if (!hit) state_d = RD_REQ;
                  end
         RD_REQ:  if (mem_req_ready) begin
                     state_d = RD_BEAT;
                     beat_d  = '0;
                  end
         RD_BEAT: if (mem_rvalid) begin
                     beat_d = beat_q + 1'b1;
                     if (last_beat) state_d = IDLE;
                  end
         WR:      if (mem_req_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall         = 1'b0;
      rdata         = '0;
      mem_req_valid = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      case (state_q)
         IDLE: begin
            stall = req_valid && (req_we || !hit);
            if (req_valid && !req_we && hit) rdata = data_q[index][offset];
         end
         RD_REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
            mem_addr      = {tag, index, {(OFF_W+2){1'b0}}};
         end
         RD_BEAT: stall = 1'b1;
         WR: begin
            stall         = !mem_req_ready;
            mem_req_valid = 1'b1;
            mem_we        = 1'b1;
            mem_addr      = {req_addr[WIDTH-1:2], 2'b00};
            mem_wdata     = req_wdata;
         end
         default: ;
      endcase
   end

   // The target line is invalidated once the burst starts so a partial line never hits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                   valid_q        <= '0;
      else if ((state_q == RD_REQ) && mem_req_ready) valid_q[index] <= 1'b0;
      else if ((state_q == RD_BEAT) && last_beat) valid_q[index] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (refill_we)                             data_q[index][beat_q] <= mem_rdata;
      if ((state_q == RD_BEAT) && last_beat)     tag_q[index]          <= tag;
      if (store_hit_we)                          data_q[index][offset] <= req_wdata;
   end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a line-level cache model predicts every cycle's
// outputs, a negedge compare process checks them, and a few literals pin the model.
module tb_data_cache;
   logic        clk = 1'b0, rst = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic        stall, mem_req_valid, mem_we;
   logic        mem_req_ready = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   data_cache dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata), .stall(stall),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   int checks = 0, failures = 0;
   bit chk_en = 1'b0;
   logic        exp_stall, exp_mrv, exp_mwe;
   logic [31:0] exp_maddr, exp_mwdata, exp_rdata;
   bit          exp_rd_chk, exp_rst;

   // Reference cache contents, one entry per set.
   bit          m_valid [64];
   logic [21:0] m_tag   [64];
   logic [31:0] m_data  [64][4];

   function automatic int m_idx(input logic [31:0] a); return int'((a >> 4) % 64); endfunction
   function automatic int m_off(input logic [31:0] a); return int'((a >> 2) % 4);  endfunction
   function automatic logic [21:0] m_tagof(input logic [31:0] a); return 22'(a >> 10); endfunction
   function automatic bit m_hit(input logic [31:0] a);
      return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic step(); @(posedge clk); #1; endtask

   task automatic set_idle_exp();
      exp_stall = 0; exp_mrv = 0; exp_mwe = 0; exp_maddr = '0; exp_mwdata = '0;
      exp_rdata = '0; exp_rd_chk = 0; exp_rst = 0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", {31'd0, stall}, {31'd0, exp_stall});
         chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, exp_mrv});
         if (exp_mrv || exp_rst) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, exp_mwe});
            chk("mem_addr", mem_addr, exp_maddr);
            if (exp_mwe || exp_rst) chk("mem_wdata", mem_wdata, exp_mwdata);
         end
         if (exp_rd_chk) chk("rdata", rdata, exp_rdata);
      end
   end

   task automatic idle(input int n, input bit stray);
      for (int i = 0; i < n; i++) begin
         req_valid = 0; mem_rvalid = stray; mem_rdata = $urandom;
         set_idle_exp(); step();
      end
      mem_rvalid = 0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] b0, b1, b2, b3,
                          input int dly, input bit use_lit, input logic [31:0] lit);
      logic [31:0] beats [4];
      beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
      req_valid = 1; req_we = 0; req_addr = a; req_wdata = $urandom;
      if (!m_hit(a)) begin
         set_idle_exp(); exp_stall = 1; step();
         exp_mrv = 1; exp_maddr = a & ~32'hF;
         for (int i = 0; i < dly; i++) begin mem_req_ready = 0; step(); end
         mem_req_ready = 1; step(); mem_req_ready = 0;
         set_idle_exp(); exp_stall = 1;
         for (int b = 0; b < 4; b++) begin
            if (b == 2) begin mem_rvalid = 0; step(); end
            mem_rvalid = 1; mem_rdata = beats[b]; step();
         end
         mem_rvalid = 0;
         m_valid[m_idx(a)] = 1; m_tag[m_idx(a)] = m_tagof(a);
         for (int k = 0; k < 4; k++) m_data[m_idx(a)][k] = beats[k];
      end
      set_idle_exp(); exp_rd_chk = 1; exp_rdata = m_data[m_idx(a)][m_off(a)];
      if (use_lit) begin @(negedge clk); chk("load_literal", rdata, lit); end
      step();
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int dly);
      req_valid = 1; req_we = 1; req_addr = a; req_wdata = d;
      set_idle_exp(); exp_stall = 1; step();
      exp_mrv = 1; exp_mwe = 1; exp_maddr = a & ~32'h3; exp_mwdata = d;
      for (int i = 0; i < dly; i++) begin mem_req_ready = 0; exp_stall = 1; step(); end
      mem_req_ready = 1; exp_stall = 0; step(); mem_req_ready = 0;
      if (m_hit(a)) m_data[m_idx(a)][m_off(a)] = d;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      set_idle_exp(); exp_rst = 1; exp_rd_chk = 1; exp_rdata = '0;
      #1 chk_en = 1;
      step(); step();
      rst = 1; set_idle_exp(); step();

      do_load(32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1, 1, 32'hA0);
      do_load(32'h10C, 0, 0, 0, 0, 0, 1, 32'hA3);
      do_store(32'h104, 32'hDEAD, 3);
      do_load(32'h104, 0, 0, 0, 0, 0, 1, 32'hDEAD);
      idle(2, 0);

      do_store(32'h2000, 32'h55, 0);
      do_load(32'h2000, 32'h55, 32'hB1, 32'hB2, 32'hB3, 0, 1, 32'h55);

      do_load(32'h500, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 2, 1, 32'hC0);
      do_load(32'h100, 32'hA0, 32'hDEAD, 32'hA2, 32'hA3, 0, 1, 32'hA0);
      for (int i = 0; i < 4; i++) do_load(32'h108, 0, 0, 0, 0, 0, 1, 32'hA2);
      idle(1, 0);

      // Abandon a refill of 0x300 after its second beat.
      req_valid = 1; req_we = 0; req_addr = 32'h300;
      set_idle_exp(); exp_stall = 1; step();
      exp_mrv = 1; exp_maddr = 32'h300; mem_req_ready = 1; step(); mem_req_ready = 0;
      set_idle_exp(); exp_stall = 1;
      mem_rvalid = 1; mem_rdata = 32'h11; step();
      mem_rdata = 32'h22; step();
      rst = 0; mem_rvalid = 0; req_valid = 0;
      for (int i = 0; i < 64; i++) m_valid[i] = 0;
      set_idle_exp(); exp_rst = 1; exp_rd_chk = 1; exp_rdata = '0;
      step(); step();
      rst = 1; set_idle_exp(); step();
      idle(4, 1);

      do_load(32'h300, 32'h30, 32'h31, 32'h32, 32'h33, 0, 1, 32'h30);
      do_load(32'h100, 32'hA0, 32'hDEAD, 32'hA2, 32'hA3, 1, 1, 32'hA0);
      idle(2, 0);

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
